// File: rtl/spi_pkg.sv
// Shared types for the SPI master transfer engine: FSM states and the
// per-transfer configuration captured when a start request is accepted.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb_first;
    } spi_cfg_t;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period counter for the SPI master. Counts 0..H-1 while enabled and
// strobes on the last count; while edge counting is enabled it also tracks
// how many SCLK edges have been issued so the engine knows the phase of the
// next edge (leading/trailing) and when the final edge is due.
module spi_clk_gen #(
    parameter int N     = 8,
    parameter int DIV_W = 8
) (
    input  logic           clk_c,
    input  logic           reset_r,
    input  logic           enable,
    input  logic           count_edges,
    input  logic [DIV_W:0] half_period,
    output logic           edge_strobe,
    output logic           leading,
    output logic           last_edge
);

    localparam int EW = $clog2(2 * N) + 1;

    logic [DIV_W-1:0] cnt_r;
    logic [EW-1:0]    edge_idx_r;
    logic [DIV_W:0]   terminal_s;

    // Decode the terminal count and the phase of the next SCLK edge.
    always_comb begin
        terminal_s  = half_period - {{DIV_W{1'b0}}, 1'b1};
        edge_strobe = enable && ({1'b0, cnt_r} == terminal_s);
        leading     = ~edge_idx_r[0];
        last_edge   = (edge_idx_r == EW'(2 * N - 1));
    end

    // Half-period counter; restarts at every strobe and idles at zero.
    always_ff @(posedge clk_c) begin
        if (reset_r) begin
            cnt_r <= '0;
        end else if (!enable || edge_strobe) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + DIV_W'(1);
        end
    end

    // Number of SCLK edges already issued in the current shift phase.
    always_ff @(posedge clk_c) begin
        if (reset_r) begin
            edge_idx_r <= '0;
        end else if (!count_edges) begin
            edge_idx_r <= '0;
        end else if (edge_strobe) begin
            edge_idx_r <= edge_idx_r + EW'(1);
        end else begin
            edge_idx_r <= edge_idx_r;
        end
    end

endmodule

// File: rtl/spi_master_engine.sv
// SPI master transfer engine: one full-duplex N-bit word per accepted start,
// runtime SCLK divider, all four CPOL/CPHA modes and MSB/LSB-first order.
// Every pin-side and handshake output is driven straight from a flop.
module spi_master_engine
    import spi_pkg::*;
#(
    parameter int N     = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk_c,
    input  logic             reset_r,
    input  logic             start_i,
    input  logic [N-1:0]     data_i,
    input  logic             cpol_i,
    input  logic             cpha_i,
    input  logic             lsb_first_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             miso_i,
    output logic             sclk_o,
    output logic             mosi_o,
    output logic             cs_n_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [N-1:0]     q_o
);

    state_t         state_r;
    state_t         next_state_s;
    spi_cfg_t       cfg_r;
    logic [DIV_W:0] half_r;
    logic [N-1:0]   tx_r;
    logic [N-1:0]   rx_r;

    logic clk_en_s;
    logic shift_s;
    logic edge_strobe_s;
    logic leading_s;
    logic last_edge_s;
    logic shift_edge_s;
    logic tx_adv_s;
    logic rx_smp_s;

    // Bit that goes on the wire next, given the remaining transmit bits.
    function automatic logic head_bit(input logic [N-1:0] w, input logic lsb);
        return lsb ? w[0] : w[N-1];
    endfunction

    // Remaining transmit bits after the head bit has been sent.
    function automatic logic [N-1:0] drop_head(input logic [N-1:0] w, input logic lsb);
        return lsb ? {1'b0, w[N-1:1]} : {w[N-2:0], 1'b0};
    endfunction

    // Append a received bit so the word reads in wire order.
    function automatic logic [N-1:0] push_rx(input logic [N-1:0] w, input logic lsb,
                                             input logic b);
        return lsb ? {b, w[N-1:1]} : {w[N-2:0], b};
    endfunction

    spi_clk_gen #(
        .N     (N),
        .DIV_W (DIV_W)
    ) u_clk_gen (
        .clk_c       (clk_c),
        .reset_r     (reset_r),
        .enable      (clk_en_s),
        .count_edges (shift_s),
        .half_period (half_r),
        .edge_strobe (edge_strobe_s),
        .leading     (leading_s),
        .last_edge   (last_edge_s)
    );

    // Run the half-period counter in every timed state; count edges in SHIFT.
    always_comb begin
        clk_en_s = 1'b0;
        shift_s  = 1'b0;
        case (state_r)
            SETUP, HOLD: begin
                clk_en_s = 1'b1;
            end
            SHIFT: begin
                clk_en_s = 1'b1;
                shift_s  = 1'b1;
            end
            default: begin
                clk_en_s = 1'b0;
                shift_s  = 1'b0;
            end
        endcase
    end

    // Map SCLK edges to transmit-advance and receive-sample events per CPHA.
    always_comb begin
        shift_edge_s = shift_s && edge_strobe_s;
        tx_adv_s     = 1'b0;
        rx_smp_s     = 1'b0;
        if (cfg_r.cpha) begin
            tx_adv_s = shift_edge_s && leading_s;
            rx_smp_s = shift_edge_s && !leading_s;
        end else begin
            // The first bit is already on MOSI, so the final trailing edge has nothing to shift out.
            tx_adv_s = shift_edge_s && !leading_s && !last_edge_s;
            rx_smp_s = shift_edge_s && leading_s;
        end
    end

    // Next-state logic for the transfer sequence.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_i) next_state_s = SETUP;
                else         next_state_s = IDLE;
            end
            SETUP: begin
                if (edge_strobe_s) next_state_s = SHIFT;
                else               next_state_s = SETUP;
            end
            SHIFT: begin
                if (edge_strobe_s && last_edge_s) next_state_s = HOLD;
                else                              next_state_s = SHIFT;
            end
            HOLD: begin
                if (edge_strobe_s) next_state_s = DONE;
                else               next_state_s = HOLD;
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_c) begin
        if (reset_r) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Configuration latch, shift registers and registered pin/handshake outputs.
    always_ff @(posedge clk_c) begin
        if (reset_r) begin
            cfg_r   <= '0;
            half_r  <= '0;
            tx_r    <= '0;
            rx_r    <= '0;
            sclk_o  <= 1'b0;
            mosi_o  <= 1'b0;
            cs_n_o  <= 1'b1;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            q_o     <= '0;
        end else begin
            done_o <= 1'b0;
            case (state_r)
                IDLE: begin
                    sclk_o <= cpol_i;
                    cs_n_o <= 1'b1;
                    busy_o <= 1'b0;
                    if (start_i) begin
                        cfg_r.cpol      <= cpol_i;
                        cfg_r.cpha      <= cpha_i;
                        cfg_r.lsb_first <= lsb_first_i;
                        half_r          <= {1'b0, div_i} + {{DIV_W{1'b0}}, 1'b1};
                        rx_r            <= '0;
                        busy_o          <= 1'b1;
                        cs_n_o          <= 1'b0;
                        if (!cpha_i) begin
                            // CPHA=0 presents the first bit before the first edge.
                            mosi_o <= head_bit(data_i, lsb_first_i);
                            tx_r   <= drop_head(data_i, lsb_first_i);
                        end else begin
                            mosi_o <= 1'b0;
                            tx_r   <= data_i;
                        end
                    end
                end
                SETUP: begin
                    sclk_o <= cfg_r.cpol;
                end
                SHIFT: begin
                    if (edge_strobe_s) begin
                        sclk_o <= ~sclk_o;
                    end
                    if (tx_adv_s) begin
                        mosi_o <= head_bit(tx_r, cfg_r.lsb_first);
                        tx_r   <= drop_head(tx_r, cfg_r.lsb_first);
                    end
                    if (rx_smp_s) begin
                        rx_r <= push_rx(rx_r, cfg_r.lsb_first, miso_i);
                    end
                end
                HOLD: begin
                    sclk_o <= cfg_r.cpol;
                    if (edge_strobe_s) begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        cs_n_o <= 1'b1;
                        q_o    <= rx_r;
                    end
                end
                DONE: begin
                    sclk_o <= cfg_r.cpol;
                    cs_n_o <= 1'b1;
                    busy_o <= 1'b0;
                end
                default: begin
                    sclk_o <= 1'b0;
                    cs_n_o <= 1'b1;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_engine.sv
// Self-checking bench for spi_master_engine. A behavioural SPI slave drives
// MISO and captures MOSI on its capture edges; expectations come from the
// wire-order rules of the protocol and simple timing arithmetic.
module tb_spi_master_engine;

    localparam int N     = 8;
    localparam int DIV_W = 8;

    logic             clk_c = 1'b0;
    logic             reset_r;
    logic             start_i;
    logic [N-1:0]     data_i;
    logic             cpol_i;
    logic             cpha_i;
    logic             lsb_first_i;
    logic [DIV_W-1:0] div_i;
    logic             miso_i;
    logic             sclk_o;
    logic             mosi_o;
    logic             cs_n_o;
    logic             busy_o;
    logic             done_o;
    logic [N-1:0]     q_o;

    bit   loop_en;
    logic miso_drv;
    int   checks = 0;
    int   errors = 0;

    assign miso_i = loop_en ? mosi_o : miso_drv;

    always #5 clk_c = ~clk_c;

    spi_master_engine #(
        .N     (N),
        .DIV_W (DIV_W)
    ) dut (
        .clk_c       (clk_c),
        .reset_r     (reset_r),
        .start_i     (start_i),
        .data_i      (data_i),
        .cpol_i      (cpol_i),
        .cpha_i      (cpha_i),
        .lsb_first_i (lsb_first_i),
        .div_i       (div_i),
        .miso_i      (miso_i),
        .sclk_o      (sclk_o),
        .mosi_o      (mosi_o),
        .cs_n_o      (cs_n_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .q_o         (q_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // k-th bit on the wire for a word sent in the selected order.
    function automatic logic wire_bit(input logic [N-1:0] w, input bit lsb, input int k);
        return lsb ? w[k] : w[N-1-k];
    endfunction

    // One complete transfer with the slave model attached.
    task automatic run_xfer(input string tag, input logic [N-1:0] data, input bit cpol,
                            input bit cpha, input bit lsb, input logic [DIV_W-1:0] div,
                            input bit loop, input logic [N-1:0] pat, input bit spurious);
        int h;
        int edges;
        int leads;
        int done_cyc;
        int first_lead;
        int second_lead;
        int mbits;
        int sbit;
        int cs_bad;
        logic [N-1:0] cap;
        logic [N-1:0] exp_q;
        logic prev;
        h = int'(div) + 1;
        exp_q = loop ? data : pat;
        @(posedge clk_c); #1;
        data_i      = data;
        cpol_i      = cpol;
        cpha_i      = cpha;
        lsb_first_i = lsb;
        div_i       = div;
        loop_en     = loop;
        start_i     = 1'b1;
        miso_drv    = wire_bit(pat, lsb, 0);
        sbit        = cpha ? 0 : 1;
        @(posedge clk_c); #1;
        start_i = 1'b0;
        check({tag, "_busy_rise"}, 32'(busy_o), 32'd1);
        check({tag, "_cs_low"}, 32'(cs_n_o), 32'd0);
        check({tag, "_sclk_idle_setup"}, 32'(sclk_o), 32'(cpol));
        prev = sclk_o;
        edges = 0; leads = 0; done_cyc = -1; first_lead = -1; second_lead = -1;
        mbits = 0; cs_bad = 0; cap = '0;
        for (int cyc = 1; cyc <= (2 * N + 2) * h + 8; cyc++) begin
            @(posedge clk_c); #1;
            start_i = spurious && (cyc == 3 * h);
            if (spurious && cyc == 3 * h) begin
                data_i      = '1;
                cpol_i      = ~cpol;
                cpha_i      = ~cpha;
                lsb_first_i = ~lsb;
                div_i       = ~div;
            end
            if (sclk_o !== prev) begin
                edges++;
                if (sclk_o !== cpol) begin
                    leads++;
                    if (first_lead < 0) first_lead = cyc;
                    else if (second_lead < 0) second_lead = cyc;
                    if (!cpha) begin
                        if (mbits < N) cap[lsb ? mbits : N - 1 - mbits] = mosi_o;
                        mbits++;
                    end else if (sbit < N) begin
                        miso_drv = wire_bit(pat, lsb, sbit);
                        sbit++;
                    end
                end else begin
                    if (cpha) begin
                        if (mbits < N) cap[lsb ? mbits : N - 1 - mbits] = mosi_o;
                        mbits++;
                    end else if (sbit < N) begin
                        miso_drv = wire_bit(pat, lsb, sbit);
                        sbit++;
                    end
                end
                prev = sclk_o;
            end
            if (done_o === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            if (cs_n_o !== 1'b0) cs_bad++;
        end
        start_i = 1'b0;
        check({tag, "_done_latency"}, 32'(done_cyc), 32'((2 * N + 2) * h));
        check({tag, "_q"}, 32'(q_o), 32'(exp_q));
        check({tag, "_mosi_word"}, 32'(cap), 32'(data));
        check({tag, "_edges"}, 32'(edges), 32'(2 * N));
        check({tag, "_leading_edges"}, 32'(leads), 32'(N));
        check({tag, "_sclk_period"}, 32'(second_lead - first_lead), 32'(2 * h));
        check({tag, "_cs_during"}, 32'(cs_bad), 32'd0);
        check({tag, "_busy_at_done"}, 32'(busy_o), 32'd0);
        check({tag, "_cs_at_done"}, 32'(cs_n_o), 32'd1);
        check({tag, "_sclk_idle_done"}, 32'(sclk_o), 32'(cpol));
        @(posedge clk_c); #1;
        check({tag, "_done_single"}, 32'(done_o), 32'd0);
        check({tag, "_q_held"}, 32'(q_o), 32'(exp_q));
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int edges;
        int dcount;
        logic prev;
        logic [N-1:0] rdata;
        logic [N-1:0] rpat;
        reset_r = 1'b1; start_i = 1'b0; data_i = '0; cpol_i = 1'b0; cpha_i = 1'b0;
        lsb_first_i = 1'b0; div_i = '0; loop_en = 1'b0; miso_drv = 1'b0;
        repeat (3) @(posedge clk_c);
        #1;
        check("rst_sclk", 32'(sclk_o), 32'd0);
        check("rst_mosi", 32'(mosi_o), 32'd0);
        check("rst_cs_n", 32'(cs_n_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_q", 32'(q_o), 32'd0);
        reset_r = 1'b0;

        run_xfer("t1_mode0_msb", 8'hA5, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 8'h00, 1'b0);
        run_xfer("t2_mode3", 8'h3C, 1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 8'hC3, 1'b0);
        run_xfer("t3_lsb_mode1", 8'h01, 1'b0, 1'b1, 1'b1, 8'd1, 1'b1, 8'h00, 1'b0);
        run_xfer("t4_spurious", 8'h5A, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 8'h00, 1'b1);

        // Reset in the middle of the shift phase.
        @(posedge clk_c); #1;
        data_i = 8'h96; cpol_i = 1'b1; cpha_i = 1'b0; lsb_first_i = 1'b0; div_i = 8'd1;
        loop_en = 1'b1; start_i = 1'b1;
        @(posedge clk_c); #1;
        start_i = 1'b0;
        prev = sclk_o;
        edges = 0;
        for (int cyc = 0; cyc < 200 && edges < 4; cyc++) begin
            @(posedge clk_c); #1;
            if (sclk_o !== prev) begin
                edges++;
                prev = sclk_o;
            end
        end
        check("t5_edges_before_reset", 32'(edges), 32'd4);
        reset_r = 1'b1;
        @(posedge clk_c); #1;
        reset_r = 1'b0;
        check("t5_cs_n", 32'(cs_n_o), 32'd1);
        check("t5_busy", 32'(busy_o), 32'd0);
        check("t5_sclk", 32'(sclk_o), 32'd0);
        check("t5_q", 32'(q_o), 32'd0);
        check("t5_done", 32'(done_o), 32'd0);
        dcount = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(posedge clk_c); #1;
            if (done_o === 1'b1) dcount++;
        end
        check("t5_no_done_after_reset", 32'(dcount), 32'd0);

        run_xfer("t6_div_min", 8'hC9, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'h4E, 1'b0);
        run_xfer("t6_div_max", 8'h6B, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 8'hB2, 1'b0);

        for (int i = 0; i < 6; i++) begin
            rdata = N'($urandom);
            rpat  = N'($urandom);
            run_xfer($sformatf("rnd%0d", i), rdata, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     DIV_W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rpat, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
